mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_ctrl_if.sv | 28 ++
 rtl/rr_arbiter_2.sv | 33 +++
 rtl/mem_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-requester single-port memory controller.
package mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 10;

  // Requester indices: 0 is the load/store unit, 1 is the debug/DMA port.
  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus shared by the two requesters and the controller.
interface mem_ctrl_if #(
  parameter int DATA_WIDTH = mem_ctrl_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_ctrl_pkg::DEF_ADDR_WIDTH
);

  localparam int NUM_BE = DATA_WIDTH / 8;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_we;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic [1:0][NUM_BE-1:0]     req_be;
  logic [1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant plus a priority pointer that
// flips to the other requester after every accepted grant.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // A lone requester wins regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrated single-port memory controller: read-modify-write stores with
// byte enables, one outstanding transaction, response carries the pre-write word.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_ctrl_if.slave             bus,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_busy
);

  localparam int NUM_BE = DATA_WIDTH / 8;

  state_t                state, next_state;
  logic [1:0]            grant;
  logic                  gid;
  logic                  accept;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;
  logic                  write_en;

  logic                  lat_we;
  logic                  lat_id;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [NUM_BE-1:0]     lat_be;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  rr_arbiter_2 u_arb (
    .clk     (i_clk),
    .rst     (i_rst),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign gid = grant[REQ_DMA] ? REQ_DMA : REQ_LSU;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    write_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|grant) begin
          accept     = 1'b1;
          req_ready  = grant;
          next_state = ACCESS;
        end
      end
      ACCESS: next_state = (lat_we && (lat_be != '0)) ? WRITE : RESP;
      WRITE: begin
        write_en   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        rsp_valid[lat_id] = 1'b1;
        next_state        = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset aborts whatever is in flight in the same cycle it is asserted.
    if (i_rst) begin
      accept    = 1'b0;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      write_en  = 1'b0;
    end
  end

  // NOTE: the latched request and old-word registers are reset as well as the
  // FSM, because they drive o_mem_addr, o_mem_write_data and o_rsp_rdata directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_id    <= REQ_LSU;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      old_word  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_we    <= bus.req_we[gid];
        lat_id    <= gid;
        lat_addr  <= bus.req_addr[gid];
        lat_wdata <= bus.req_wdata[gid];
        lat_be    <= bus.req_be[gid];
      end
      if (state == ACCESS) begin
        old_word <= i_mem_read_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BE; i++) begin
      merged[i*8 +: 8] = lat_be[i] ? lat_wdata[i*8 +: 8] : old_word[i*8 +: 8];
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = old_word;
  assign o_mem_write_en    = write_en;
  assign o_mem_addr        = lat_addr;
  assign o_mem_write_data  = merged;
  assign o_busy            = (state != IDLE) && !i_rst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a behavioural memory answers the controller and
// each step compares DUT outputs against hand-computed values.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .bus              (bus),
    .o_mem_write_en   (mem_we),
    .o_mem_addr       (mem_addr),
    .o_mem_write_data (mem_wdata),
    .i_mem_read_data  (mem_rdata),
    .o_busy           (busy)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int id, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    bus.req_addr[id]  = addr;
    bus.req_wdata[id] = wdata;
    bus.req_be[id]    = be;
  endtask

  logic [1:0]    exp_g;
  logic [DW-1:0] exp_d;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h005] = 64'h1122334455667788;
    mem[10'h010] = 64'h0123456789ABCDEF;
    mem[10'h020] = 64'hDEADBEEFCAFEF00D;
    mem[10'h040] = 64'h9999999999999999;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    rst = 1'b1;

    // Reset state
    cycle();
    cycle();
    #1;
    check("rst_ready",  bus.req_ready, 2'b00);
    check("rst_rsp",    bus.rsp_valid, 2'b00);
    check("rst_rdata",  bus.rsp_rdata, 64'h0);
    check("rst_we",     mem_we, 1'b0);
    check("rst_addr",   mem_addr, 10'h0);
    check("rst_wdata",  mem_wdata, 64'h0);
    check("rst_busy",   busy, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    check("rst_ready_with_valid", bus.req_ready, 2'b00);
    bus.req_valid = 2'b00;
    cycle();
    rst = 1'b0;
    cycle();

    // Load from requester 0, addr 0x005
    req(0, 1'b0, 10'h005, 64'h0, 8'h00);
    #1;
    check("ld_ready_T",  bus.req_ready, 2'b01);
    check("ld_busy_T",   busy, 1'b0);
    cycle();
    bus.req_valid = 2'b00;
    #1;
    check("ld_ready_T1", bus.req_ready, 2'b00);
    check("ld_busy_T1",  busy, 1'b1);
    check("ld_rsp_T1",   bus.rsp_valid, 2'b00);
    check("ld_we_T1",    mem_we, 1'b0);
    check("ld_addr_T1",  mem_addr, 10'h005);
    cycle();
    #1;
    check("ld_rsp_T2",   bus.rsp_valid, 2'b01);
    check("ld_rdata_T2", bus.rsp_rdata, 64'h1122334455667788);
    check("ld_we_T2",    mem_we, 1'b0);
    cycle();
    #1;
    check("ld_rsp_T3",   bus.rsp_valid, 2'b00);
    check("ld_busy_T3",  busy, 1'b0);
    check("ld_addr_hold", mem_addr, 10'h005);

    // Partial store from requester 1, be=0x0F
    req(1, 1'b1, 10'h010, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    #1;
    check("ps_ready_T",  bus.req_ready, 2'b10);
    cycle();
    bus.req_valid = 2'b00;
    #1;
    check("ps_we_T1",    mem_we, 1'b0);
    check("ps_addr_T1",  mem_addr, 10'h010);
    cycle();
    #1;
    check("ps_we_T2",    mem_we, 1'b1);
    check("ps_wdata_T2", mem_wdata, 64'h01234567BBBBBBBB);
    check("ps_addr_T2",  mem_addr, 10'h010);
    check("ps_rsp_T2",   bus.rsp_valid, 2'b00);
    cycle();
    #1;
    check("ps_rsp_T3",   bus.rsp_valid, 2'b10);
    check("ps_rdata_T3", bus.rsp_rdata, 64'h0123456789ABCDEF);
    check("ps_we_T3",    mem_we, 1'b0);
    check("ps_mem",      mem[10'h010], 64'h01234567BBBBBBBB);
    cycle();

    // Store with be=0 from requester 0: behaves as a read
    req(0, 1'b1, 10'h020, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    #1;
    check("z_ready_T",  bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b00;
    #1;
    check("z_we_T1",    mem_we, 1'b0);
    cycle();
    #1;
    check("z_rsp_T2",   bus.rsp_valid, 2'b01);
    check("z_rdata_T2", bus.rsp_rdata, 64'hDEADBEEFCAFEF00D);
    check("z_we_T2",    mem_we, 1'b0);
    cycle();
    #1;
    check("z_mem",      mem[10'h020], 64'hDEADBEEFCAFEF00D);

    // Full store then load of the same address (pointer now favours 1; lone req0 still wins)
    req(0, 1'b1, 10'h030, 64'h55AA55AA12345678, 8'hFF);
    #1;
    check("fs_ready_T",  bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b00;
    cycle();
    #1;
    check("fs_we_T2",    mem_we, 1'b1);
    check("fs_wdata_T2", mem_wdata, 64'h55AA55AA12345678);
    cycle();
    #1;
    check("fs_rsp_T3",   bus.rsp_valid, 2'b01);
    check("fs_rdata_T3", bus.rsp_rdata, 64'h0);
    cycle();
    req(1, 1'b0, 10'h030, 64'h0, 8'h00);
    #1;
    check("fl_ready_T",  bus.req_ready, 2'b10);
    cycle();
    bus.req_valid = 2'b00;
    cycle();
    #1;
    check("fl_rsp_T2",   bus.rsp_valid, 2'b10);
    check("fl_rdata_T2", bus.rsp_rdata, 64'h55AA55AA12345678);
    cycle();

    // Contention after reset: both hold valid, loads alternate 0,1,0,1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req(0, 1'b0, 10'h005, 64'h0, 8'h00);
    req(1, 1'b0, 10'h010, 64'h0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_g = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = exp_g[0] ? 64'h1122334455667788 : 64'h01234567BBBBBBBB;
      check($sformatf("ct_ready_%0d", i), bus.req_ready, (i % 3 == 0) ? exp_g : 2'b00);
      check($sformatf("ct_rsp_%0d", i),   bus.rsp_valid, (i % 3 == 2) ? exp_g : 2'b00);
      if (i % 3 == 2) check($sformatf("ct_rdata_%0d", i), bus.rsp_rdata, exp_d);
      cycle();
    end
    bus.req_valid = 2'b00;
    #1;
    check("ct_ready_end", bus.req_ready, 2'b00);
    check("ct_busy_end",  busy, 1'b0);

    // Reset asserted while in WRITE aborts the store
    req(0, 1'b1, 10'h040, 64'h1111111111111111, 8'hFF);
    #1;
    check("ab_ready_T", bus.req_ready, 2'b01);
    cycle();
    bus.req_valid = 2'b00;
    #1;
    check("ab_busy_T1", busy, 1'b1);
    cycle();
    #1;
    check("ab_we_T2",   mem_we, 1'b1);
    rst = 1'b1;
    #1;
    check("ab_we_rst",  mem_we, 1'b0);
    check("ab_rsp_rst", bus.rsp_valid, 2'b00);
    cycle();
    rst = 1'b0;
    #1;
    check("ab_busy_after", busy, 1'b0);
    check("ab_we_after",   mem_we, 1'b0);
    check("ab_rsp_after",  bus.rsp_valid, 2'b00);
    check("ab_addr_after", mem_addr, 10'h0);
    check("ab_mem",        mem[10'h040], 64'h9999999999999999);
    cycle();
    #1;
    check("ab_rsp_late",   bus.rsp_valid, 2'b00);
    check("ab_ready_late", bus.req_ready, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
